// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants, scan-control bundle and colour expansion helpers
// shared by the scan-out top and its delay line.
package vga_timing_pkg;

    localparam int CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t H_VISIBLE = 11'd640;
    localparam cnt_t H_FP      = 11'd16;
    localparam cnt_t H_SYNC    = 11'd96;
    localparam cnt_t H_TOTAL   = 11'd800;
    localparam cnt_t V_VISIBLE = 11'd480;
    localparam cnt_t V_FP      = 11'd10;
    localparam cnt_t V_SYNC    = 11'd2;
    localparam cnt_t V_TOTAL   = 11'd525;

    // Sync windows are half-open: [START, END).
    localparam cnt_t H_SYNC_START = H_VISIBLE + H_FP;
    localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam cnt_t V_SYNC_START = V_VISIBLE + V_FP;
    localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic visible;
        logic hsync_n;
        logic vsync_n;
    } scan_ctrl_t;

    localparam scan_ctrl_t CTRL_RESET = '{visible: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

    // Replicate MSBs so full-scale input maps to full-scale DAC code.
    function automatic logic [3:0] expand3(input logic [2:0] c);
        return {c, c[2]};
    endfunction

    function automatic logic [3:0] expand2(input logic [1:0] c);
        return {c, c};
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that re-times scan control bits so they line up
// with the colour pipeline; each bit has its own reset value.
module sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset, not just the output one -- these hold sync
    // levels, and an unreset stage would leak a stale pulse after reset release.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample its
            // predecessor's old value, giving a true DEPTH-cycle shift.
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_out.sv
// VGA 640x480 scan generator: free-running H/V counters drive the objects mux,
// and sync/blank are delayed to meet the mux colour at the DAC.
module vga_scan_out
    import vga_timing_pkg::*;
#(
    parameter int MUX_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [3:0]  oVGA_R,
    output logic [3:0]  oVGA_G,
    output logic [3:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_BLANK_N
);

    cnt_t       hcnt_q, hcnt_d;
    cnt_t       vcnt_q, vcnt_d;
    logic       h_wrap;
    scan_ctrl_t raw_ctrl;
    scan_ctrl_t dly_ctrl;
    logic [7:0] rgb_q;

    // NOTE: always_comb assigns every output a default before any branch so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        h_wrap = 1'b0;
        hcnt_d = hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_TOTAL - 11'd1) begin
            h_wrap = 1'b1;
            hcnt_d = '0;
        end
        if (h_wrap) begin
            vcnt_d = (vcnt_q == V_TOTAL - 11'd1) ? '0 : vcnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            rgb_q  <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            rgb_q  <= RGBIn;
        end
    end

    always_comb begin
        raw_ctrl.visible = (hcnt_q < H_VISIBLE) && (vcnt_q < V_VISIBLE);
        raw_ctrl.hsync_n = !((hcnt_q >= H_SYNC_START) && (hcnt_q < H_SYNC_END));
        raw_ctrl.vsync_n = !((vcnt_q >= V_SYNC_START) && (vcnt_q < V_SYNC_END));
    end

    // One extra stage covers the RGBIn register after the mux latency.
    sync_delay_line #(
        .WIDTH    ($bits(scan_ctrl_t)),
        .DEPTH    (MUX_LATENCY + 1),
        .RESET_VAL(CTRL_RESET)
    ) u_ctrl_dly (
        .clk   (clk),
        .resetN(resetN),
        .d_i   (raw_ctrl),
        .q_o   (dly_ctrl)
    );

    assign pixelX       = hcnt_q;
    assign pixelY       = vcnt_q;
    assign startOfFrame = (hcnt_q == H_TOTAL - 11'd1) && (vcnt_q == V_TOTAL - 11'd1);

    // Colour is forced to black outside the visible window, so blanking-time
    // RGBIn never reaches the DAC.
    assign oVGA_R       = dly_ctrl.visible ? expand3(rgb_q[7:5]) : 4'h0;
    assign oVGA_G       = dly_ctrl.visible ? expand3(rgb_q[4:2]) : 4'h0;
    assign oVGA_B       = dly_ctrl.visible ? expand2(rgb_q[1:0]) : 4'h0;
    assign oVGA_HS      = dly_ctrl.hsync_n;
    assign oVGA_VS      = dly_ctrl.vsync_n;
    assign oVGA_BLANK_N = dly_ctrl.visible;

endmodule
